ifft_stage3_bf_sched: RTL

- Frame-level scheduler for stage 3 (8-point butterfly stage) of the 32-point IFFT.
- Collects one 32-sample frame of S3.9 complex data over a valid/ready stream into an input buffer.
- Time-multiplexes a single internal sum/difference butterfly across the 16 stage-3 pairs (span 4 within each 8-sample group), one pair per clock.
- Streams the 32 S4.9 results out in natural order. Sits between the stage-2 output and the stage-4 input.

---
 rtl/ifft_stage3_bf_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ifft_stage3_bf_sched.sv
// Stage-3 butterfly scheduler for the 32-point IFFT.
// Buffers one frame, runs a single sum/difference butterfly over the
// sixteen span-4 pairs (one pair per clock), then streams the widened
// results out in natural order.
module ifft_stage3_bf_sched #(
  parameter int N    = 32,
  parameter int SPAN = 4,
  parameter int IW   = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_real,
  input  logic [IW-1:0] in_imag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW:0]   out_real,
  output logic [IW:0]   out_imag,
  output logic          out_last,
  output logic          busy
);

  localparam int AW = $clog2(N);
  localparam int OW = $clog2(N / 2);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [OW-1:0] LAST_OP  = OW'(N / 2 - 1);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [OW-1:0]   r_op;
  logic [AW-1:0]   w_u;
  logic [AW-1:0]   w_l;
  logic            w_in_fire;
  logic            w_out_fire;

  logic signed [IW-1:0] r_ibuf_re [N];
  logic signed [IW-1:0] r_ibuf_im [N];
  logic signed [IW:0]   r_obuf_re [N];
  logic signed [IW:0]   r_obuf_im [N];
  logic signed [IW:0]   w_sum_re;
  logic signed [IW:0]   w_dif_re;
  logic signed [IW:0]   w_sum_im;
  logic signed [IW:0]   w_dif_im;

  // One-bit sign extension; the extra bit absorbs the butterfly growth.
  function automatic logic signed [IW:0] sx(input logic signed [IW-1:0] a);
    return {a[IW-1], a};
  endfunction

  assign w_in_fire  = (r_state == S_LOAD) && in_valid;
  assign w_out_fire = (r_state == S_UNLOAD) && out_ready;

  // Pair addresses: upper leg u = 8g+m, lower leg l = u+SPAN.
  assign w_u = AW'((int'(r_op) / SPAN) * (2 * SPAN) + (int'(r_op) % SPAN));
  assign w_l = w_u + AW'(SPAN);

  assign w_sum_re = sx(r_ibuf_re[w_u]) + sx(r_ibuf_re[w_l]);
  assign w_dif_re = sx(r_ibuf_re[w_u]) - sx(r_ibuf_re[w_l]);
  assign w_sum_im = sx(r_ibuf_im[w_u]) + sx(r_ibuf_im[w_l]);
  assign w_dif_im = sx(r_ibuf_im[w_u]) - sx(r_ibuf_im[w_l]);

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_next;
  end

  // Next-state: advance on last accept, last op, last output handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:    if (w_in_fire && (r_wr == LAST_IDX)) w_next = S_COMPUTE;
      S_COMPUTE: if (r_op == LAST_OP) w_next = S_UNLOAD;
      S_UNLOAD:  if (w_out_fire && (r_rd == LAST_IDX)) w_next = S_LOAD;
      default:   w_next = S_LOAD;
    endcase
  end

  // Write, op and read counters; each wraps to zero on its final step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_op <= '0;
      r_rd <= '0;
    end else begin
      if (w_in_fire) r_wr <= (r_wr == LAST_IDX) ? '0 : r_wr + 1'b1;
      if (r_state == S_COMPUTE) r_op <= (r_op == LAST_OP) ? '0 : r_op + 1'b1;
      if (w_out_fire) r_rd <= (r_rd == LAST_IDX) ? '0 : r_rd + 1'b1;
    end
  end

  // Input buffer capture; data storage is never reset.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_ibuf_re[r_wr] <= $signed(in_real);
      r_ibuf_im[r_wr] <= $signed(in_imag);
    end
  end

  // Butterfly results land in both legs of the current pair.
  always_ff @(posedge clk) begin
    if (r_state == S_COMPUTE) begin
      r_obuf_re[w_u] <= w_sum_re;
      r_obuf_re[w_l] <= w_dif_re;
      r_obuf_im[w_u] <= w_sum_im;
      r_obuf_im[w_l] <= w_dif_im;
    end
  end

  // Outputs decoded from state; data is zero outside UNLOAD.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    out_real  = '0;
    out_imag  = '0;
    case (r_state)
      S_LOAD:    in_ready = 1'b1;
      S_COMPUTE: busy = 1'b1;
      S_UNLOAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (r_rd == LAST_IDX);
        out_real  = r_obuf_re[r_rd];
        out_imag  = r_obuf_im[r_rd];
      end
      default: in_ready = 1'b0;
    endcase
  end

endmodule
